fpu_issue_tracker: RTL and testbench
====================================

# fpu_issue_tracker

Tracks floating-point instructions issued from ID through the three FPU execute stages (E1, E2, E3). It produces the per-stage write-enable and destination-register signals that the pipeline control unit uses for FP hazard stalls and forwarding. It also runs the iterative-occupancy counter for fdiv/fsqrt and drives `stall_div_sqrt` back to the control unit. It is the FPU-side responder to the control unit's `wf`/`fc` issue interface.

## Interface

Parameters:
- `DIV_ITER`, default 14: cycles an fdiv occupies E1 (≥1).
- `SQRT_ITER`, default 14: cycles an fsqrt occupies E1 (≥1).

Ports:
- `clk` input, 1: clock. Single clock domain; all state updates on the rising edge.
- `rst` input, 1: reset. Synchronous, active-high.
- `wf` input, 1: FP arithmetic instruction issued this cycle (already qualified by `wpcir`).
- `fc` input, 3: op code. 000 fadd, 001 fsub, 01x fmul, 10x fdiv, 11x fsqrt.
- `fd` input, 5: destination FP register of the issuing instruction.
- `e1w`/`e2w`/`e3w` output, 1 each: stage holds a valid FP-writing instruction.
- `e1n`/`e2n`/`e3n` output, 5 each: destination register of that stage.
- `e1c`/`e2c`/`e3c` output, 3 each: op code of that stage, for datapath mux selects.
- `stall_div_sqrt` output, 1: div/sqrt iteration in progress; ID must not issue.
- `e1_iter` output, 1: E1 holds a div/sqrt that has not finished iterating (datapath iteration enable).

## Operation

- Each stage register holds {valid, n[4:0], c[2:0]}. A bubble is valid=0, n=0, c=000.
- Normal advance each cycle: E3←E2, E2←E1, E1←{wf, fd, fc}. When wf=0, E1 loads a bubble.
- Div/sqrt detect: `is_ds = fc[2]`. Iteration count: fc[1] selects SQRT_ITER, otherwise DIV_ITER.
- Counter `cnt`, width $clog2(max(DIV_ITER,SQRT_ITER)) bits (minimum 1). On issue of div/sqrt, load ITER−1. Non-div/sqrt issue loads 0.
- Hold state: E1 valid, E1 is div/sqrt, and cnt≠0.
  - E1 keeps its contents.
  - cnt decrements.
  - E2 loads a bubble.
  - E3←E2 continues, so older ops drain.
- `stall_div_sqrt = e1_iter` = hold state. Combinational from registers only, no dependence on inputs.
- wf=1 while `stall_div_sqrt`=1 is a protocol violation. The issue is ignored (E1 unchanged), and the bench flags it.
- ITER=1: no hold; div/sqrt advances like fadd.
- Reset: all valid=0, n=0, c=0, cnt=0. All outputs read 0 on the cycle after `rst` is sampled high. This holds even mid-iteration: a pending div/sqrt is discarded and the stall drops.

## Timing

- Issue at edge t (wf=1 sampled) → e1w/e1n/e1c valid during cycle t+1, E2 in t+2, E3 in t+3 for non-div/sqrt ops.
- Div/sqrt issued at t:
  - in E1 for cycles t+1 … t+ITER;
  - `stall_div_sqrt`=1 in cycles t+1 … t+ITER−1;
  - in E2 at t+ITER+1, in E3 at t+ITER+2.
- ID may issue again in cycle t+ITER (stall low). That instruction enters E1 at t+ITER+1.
- All outputs are registered or derived from registers only. There is no input-to-output combinational path.

## Structure

- Shared FP package (`fpu_pkg`) holds:
  - op-code constants FADD=3'b000, FSUB=3'b001, FMUL=3'b010, FDIV=3'b100, FSQRT=3'b110;
  - the stage-record typedef {valid, n, c};
  - helper functions `is_ds(c)` and `iter_of(c)`.
- One sub-module is natural: `fpu_ds_counter` (load/decrement/zero-detect of cnt, parameterised by both ITER values).
- The top level contains the three stage registers and the advance/hold mux.

## Test plan

- Reset, then fadd with fd=5 at t → e1w=1/e1n=5 at t+1, e2n=5 at t+2, e3n=5 at t+3, then e3w=0. stall_div_sqrt stays 0 throughout.
- Back-to-back fmul fd=3, fsub fd=4 → E1/E2/E3 show 3 then 4 on consecutive cycles, with no bubbles.
- fdiv fd=7 with DIV_ITER=14 at t → stall_div_sqrt high for exactly 13 cycles (t+1…t+13), e1n=7 for t+1…t+14, e2w=0 during the hold, e2n=7 at t+15.
- fmul fd=2 at t, fsqrt fd=9 at t+1 (SQRT_ITER=4) → fmul drains normally to E3 while fsqrt holds E1 for 4 cycles; e2w=0 for 3 cycles, then e2n=9.
- rst asserted at cycle 5 of an fdiv hold → next cycle all outputs 0 and stall_div_sqrt=0. A fresh fadd issues normally.
- wf=1 during stall_div_sqrt → E1 contents unchanged, violation flagged. DIV_ITER=1 → fdiv is never stalled.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : fpu_pkg
// Purpose  : Shared FPU op codes, stage-record type and op helper functions.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam logic [2:0] FADD  = 3'b000;
  localparam logic [2:0] FSUB  = 3'b001;
  localparam logic [2:0] FMUL  = 3'b010;
  localparam logic [2:0] FDIV  = 3'b100;
  localparam logic [2:0] FSQRT = 3'b110;

  // One execute-stage record: valid flag, destination register, op code.
  typedef struct packed {
    logic       valid;
    logic [4:0] n;
    logic [2:0] c;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  // Div and sqrt both have the top op-code bit set.
  function automatic logic is_ds(input logic [2:0] c);
    return c[2];
  endfunction

  // Iteration count for a div/sqrt op code; bit 1 separates sqrt from div.
  // The low bit is a don't-care, so it is forced high before comparing.
  function automatic int iter_of(input logic [2:0] c, input int div_iter,
                                 input int sqrt_iter);
    return ((c | 3'b001) == 3'b111) ? sqrt_iter : div_iter;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_ds_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : fpu_ds_counter
// Purpose  : Remaining-iteration counter for fdiv/fsqrt occupying E1.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module fpu_ds_counter
  import fpu_pkg::*;
#(
  parameter int DIV_ITER  = 14,
  parameter int SQRT_ITER = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec,
  input  logic       issue,
  input  logic [2:0] c,
  output logic       zero
);

  localparam int MAX_ITER = (DIV_ITER > SQRT_ITER) ? DIV_ITER : SQRT_ITER;
  localparam int CW       = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] load_val;

  // A div/sqrt issue preloads ITER-1 remaining hold cycles; anything else is 0.
  always_comb begin
    load_val = '0;
    if (issue && is_ds(c)) begin
      load_val = CW'(iter_of(c, DIV_ITER, SQRT_ITER) - 1);
    end
  end

  // Count down while E1 is held, otherwise reload from the issue slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (dec) begin
      cnt <= cnt - CW'(1);
    end else begin
      cnt <= load_val;
    end
  end

  assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/fpu_issue_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : fpu_issue_tracker
// Purpose  : E1/E2/E3 FP instruction tracking with fdiv/fsqrt E1 hold.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module fpu_issue_tracker
  import fpu_pkg::*;
#(
  parameter int DIV_ITER  = 14,
  parameter int SQRT_ITER = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wf,
  input  logic [2:0] fc,
  input  logic [4:0] fd,
  output logic       e1w,
  output logic       e2w,
  output logic       e3w,
  output logic [4:0] e1n,
  output logic [4:0] e2n,
  output logic [4:0] e3n,
  output logic [2:0] e1c,
  output logic [2:0] e2c,
  output logic [2:0] e3c,
  output logic       stall_div_sqrt,
  output logic       e1_iter
);

  stage_t e1;
  stage_t e2;
  stage_t e3;
  logic   cnt_zero;
  logic   hold;

  // E1 is held while a div/sqrt still has iterations left; registers only.
  assign hold = e1.valid & is_ds(e1.c) & ~cnt_zero;

  fpu_ds_counter #(
    .DIV_ITER  (DIV_ITER),
    .SQRT_ITER (SQRT_ITER)
  ) u_ds_counter (
    .clk   (clk),
    .rst   (rst),
    .dec   (hold),
    .issue (wf),
    .c     (fc),
    .zero  (cnt_zero)
  );

  // Stage advance; during a hold E1 freezes, E2 takes a bubble and E3 drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      e1 <= BUBBLE;
      e2 <= BUBBLE;
      e3 <= BUBBLE;
    end else begin
      e3 <= e2;
      if (hold) begin
        e2 <= BUBBLE;
      end else begin
        e2 <= e1;
        e1 <= wf ? stage_t'{valid: 1'b1, n: fd, c: fc} : BUBBLE;
      end
    end
  end

  assign e1w = e1.valid;
  assign e2w = e2.valid;
  assign e3w = e3.valid;
  assign e1n = e1.n;
  assign e2n = e2.n;
  assign e3n = e3.n;
  assign e1c = e1.c;
  assign e2c = e2.c;
  assign e3c = e3.c;

  assign stall_div_sqrt = hold;
  assign e1_iter        = hold;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_fpu_issue_tracker
// Purpose  : Directed self-checking bench for fpu_issue_tracker.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fpu_issue_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wf  = 1'b0;
  logic [2:0] fc  = 3'b000;
  logic [4:0] fd  = 5'd0;

  logic       e1w, e2w, e3w;
  logic [4:0] e1n, e2n, e3n;
  logic [2:0] e1c, e2c, e3c;
  logic       stall, iter;

  logic       a_e1w, a_e2w, a_e3w;
  logic [4:0] a_e1n, a_e2n, a_e3n;
  logic [2:0] a_e1c, a_e2c, a_e3c;
  logic       a_stall, a_iter;

  int tests = 0;
  int fails = 0;
  int viols = 0;
  int stall_cycles;

  always #5 clk = ~clk;

  fpu_issue_tracker #(.DIV_ITER(14), .SQRT_ITER(4)) dut (
    .clk(clk), .rst(rst), .wf(wf), .fc(fc), .fd(fd),
    .e1w(e1w), .e2w(e2w), .e3w(e3w),
    .e1n(e1n), .e2n(e2n), .e3n(e3n),
    .e1c(e1c), .e2c(e2c), .e3c(e3c),
    .stall_div_sqrt(stall), .e1_iter(iter)
  );

  fpu_issue_tracker #(.DIV_ITER(1), .SQRT_ITER(1)) dut1 (
    .clk(clk), .rst(rst), .wf(wf), .fc(fc), .fd(fd),
    .e1w(a_e1w), .e2w(a_e2w), .e3w(a_e3w),
    .e1n(a_e1n), .e2n(a_e2n), .e3n(a_e3n),
    .e1c(a_e1c), .e2c(a_e2c), .e3c(a_e3c),
    .stall_div_sqrt(a_stall), .e1_iter(a_iter)
  );

  // Protocol monitor: issuing while the tracker stalls is a violation.
  always @(posedge clk) begin
    if (wf && stall) viols++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [4:0] d);
    wf = 1'b1;
    fc = c;
    fd = d;
  endtask

  task automatic idle();
    wf = 1'b0;
    fc = 3'b000;
    fd = 5'd0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valids", {29'd0, e1w, e2w, e3w}, 32'd0);
    check("rst_names", {17'd0, e1n, e2n, e3n}, 32'd0);
    check("rst_codes", {23'd0, e1c, e2c, e3c}, 32'd0);
    check("rst_stall", {30'd0, stall, iter}, 32'd0);

    // Single fadd fd=5 walks E1 -> E2 -> E3 then leaves
    issue(3'b000, 5'd5);
    tick();
    idle();
    check("fadd_e1", {24'd0, stall, e1w, e1n, e1c}, {24'd0, 1'b0, 1'b1, 5'd5, 3'b000});
    tick();
    check("fadd_e2", {25'd0, e1w, e2w, e2n}, {25'd0, 1'b0, 1'b1, 5'd5});
    tick();
    check("fadd_e3", {25'd0, stall, e3w, e3n}, {25'd0, 1'b0, 1'b1, 5'd5});
    tick();
    check("fadd_gone", {31'd0, e3w}, 32'd0);

    // Back-to-back fmul fd=3, fsub fd=4
    issue(3'b010, 5'd3);
    tick();
    check("b2b_e1_first", {23'd0, e1w, e1n, e1c}, {23'd0, 1'b1, 5'd3, 3'b010});
    issue(3'b001, 5'd4);
    tick();
    idle();
    check("b2b_e1_second", {23'd0, e1w, e1n, e1c}, {23'd0, 1'b1, 5'd4, 3'b001});
    check("b2b_e2_first", {26'd0, e2w, e2n}, {26'd0, 1'b1, 5'd3});
    tick();
    check("b2b_e2_second", {20'd0, e2w, e2n, e3w, e3n}, {20'd0, 1'b1, 5'd4, 1'b1, 5'd3});
    tick();
    check("b2b_e3_second", {26'd0, e3w, e3n}, {26'd0, 1'b1, 5'd4});

    // fdiv fd=7 with DIV_ITER=14; violating issue injected mid-hold
    issue(3'b100, 5'd7);
    tick();
    idle();
    stall_cycles = 0;
    for (int k = 1; k <= 14; k++) begin
      if (stall) stall_cycles++;
      check($sformatf("div_e1_k%0d", k), {23'd0, e1w, e1n, e1c}, {23'd0, 1'b1, 5'd7, 3'b100});
      check($sformatf("div_stall_k%0d", k), {30'd0, stall, iter},
            (k <= 13) ? 32'd3 : 32'd0);
      check($sformatf("div_e2w_k%0d", k), {31'd0, e2w}, 32'd0);
      if (k == 1) check("div1_nostall", {29'd0, a_stall, a_iter, a_e1w}, 32'd1);
      if (k == 2) check("div1_e2", {26'd0, a_e2w, a_e2n}, {26'd0, 1'b1, 5'd7});
      if (k == 5) issue(3'b000, 5'd11);
      tick();
      if (k == 5) idle();
    end
    check("div_stall_count", stall_cycles, 32'd13);
    check("viol_flagged", viols, 32'd1);
    check("div_e2_out", {23'd0, e1w, e2w, e2n, e2c}, {23'd0, 1'b0, 1'b1, 5'd7, 3'b100});
    tick();
    check("div_e3_out", {26'd0, e3w, e3n}, {26'd0, 1'b1, 5'd7});
    tick();
    tick();

    // fmul fd=2 then fsqrt fd=9 (SQRT_ITER=4)
    issue(3'b010, 5'd2);
    tick();
    issue(3'b110, 5'd9);
    tick();
    idle();
    check("sq_t2", {19'd0, stall, e1w, e1n, e2w, e2n}, {19'd0, 1'b1, 1'b1, 5'd9, 1'b1, 5'd2});
    tick();
    check("sq_t3", {18'd0, stall, e1n, e2w, e3w, e3n}, {18'd0, 1'b1, 5'd9, 1'b0, 1'b1, 5'd2});
    tick();
    check("sq_t4", {25'd0, stall, e1n, e2w}, {25'd0, 1'b1, 5'd9, 1'b0});
    tick();
    check("sq_t5", {24'd0, stall, iter, e1n, e2w}, {24'd0, 1'b0, 1'b0, 5'd9, 1'b0});
    tick();
    check("sq_t6", {23'd0, e2w, e2n, e2c}, {23'd0, 1'b1, 5'd9, 3'b110});
    tick();
    tick();

    // Reset during an fdiv hold discards it
    issue(3'b100, 5'd7);
    tick();
    idle();
    for (int k = 1; k < 5; k++) tick();
    check("rst_mid_pre", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_all", {1'd0, e1w, e2w, e3w, e1n, e2n, e3n, e1c, e2c, e3c, stall, iter}, 32'd0);
    issue(3'b000, 5'd6);
    tick();
    idle();
    check("post_rst_e1", {24'd0, stall, e1w, e1n, e1c}, {24'd0, 1'b0, 1'b1, 5'd6, 3'b000});
    tick();
    check("post_rst_e2", {26'd0, e2w, e2n}, {26'd0, 1'b1, 5'd6});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
